// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared types and helpers for the sequential floating-point multiplier.
//   state_t : control FSM states
//   cls_t   : operand classification codes
//   fp_bias : exponent bias for a given exponent width
//   fp_qnan : canonical quiet NaN (sign 0, exp all-ones, fraction MSB set) in the low bits
package fp_mul_pkg;

    typedef enum logic [2:0] {IDLE, UNPACK, MUL, ROUND, DONE} state_t;

    typedef enum logic [2:0] {ZERO, SUBN, NORM, INF, QNAN, SNAN} cls_t;

    function automatic int fp_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    function automatic logic [127:0] fp_qnan(input int ew, input int mw);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < ew; i++) r[mw + i] = 1'b1;
        r[mw - 1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fp_mul_seq_lzc.sv
// fp_lzc: leading-zero counter.
//   a   : input vector (N bits)
//   cnt : number of zeros above the most significant set bit (N when a is zero)
module fp_lzc #(
    parameter int N  = 24,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  a,
    output logic [CW-1:0] cnt
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        cnt = CW'(N);
        for (int i = 0; i < N; i++) if (a[i]) cnt = CW'(N - 1 - i);
    end

endmodule

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: multi-cycle IEEE-754-style multiplier (shift-add, RNE, subnormals, flags).
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_valid, o_ready    : operand handshake (o_ready high only when idle)
//   i_a, i_b            : operands
//   o_valid, i_ready    : result handshake (result held until consumed)
//   o_res               : product
//   o_overflow, o_underflow, o_invalid, o_inexact : exception flags for o_res
module fp_mul_seq
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_res,
    output logic         o_overflow,
    output logic         o_underflow,
    output logic         o_invalid,
    output logic         o_inexact
);

    localparam int SW   = MAN_W + 1;
    localparam int PW   = 2 * SW;
    localparam int VW   = MAN_W + 3;
    localparam int LW   = $clog2(MAN_W + 2);
    localparam int CW   = $clog2(MAN_W + 1);
    localparam int XW   = EXP_W + LW + 3;
    localparam int BIAS = fp_bias(EXP_W);
    localparam logic signed [XW-1:0] EMIN = XW'(1 - BIAS);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] DMAX = XW'(VW);
    localparam logic [W-1:0]  QNAN_W  = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [PW-1:0] LO_MASK = (PW'(1) << (MAN_W - 2)) - PW'(1);

    state_t state, state_nx;
    logic [W-1:0] a_r, b_r, res_r;
    logic sign_r, ovf_r, unf_r, inv_r, inx_r;
    logic signed [XW-1:0] exp_r;
    logic [SW-1:0] ma_r, mb_r;
    logic [PW-1:0] prod_r;
    logic [CW-1:0] cnt_r;

    function automatic cls_t classify(input logic [W-1:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        e = x[W-2:MAN_W];
        f = x[MAN_W-1:0];
        if (e == '0) return (f == '0) ? ZERO : SUBN;
        if (e != '1) return NORM;
        if (f == '0) return INF;
        return f[MAN_W-1] ? QNAN : SNAN;
    endfunction

    // Unpack: classification and subnormal normalisation.
    logic [EXP_W-1:0] ea_f, eb_f;
    logic [SW-1:0] sig_a, sig_b;
    logic [LW-1:0] lza, lzb;
    logic signed [XW-1:0] ua, ub;
    cls_t ca, cb;
    logic sgn, sp_inv, sp_nan, sp_inf, special;
    logic [W-1:0] sp_res;

    assign ea_f  = a_r[W-2:MAN_W];
    assign eb_f  = b_r[W-2:MAN_W];
    assign sig_a = {|ea_f, a_r[MAN_W-1:0]};
    assign sig_b = {|eb_f, b_r[MAN_W-1:0]};
    assign ca    = classify(a_r);
    assign cb    = classify(b_r);
    assign sgn   = a_r[W-1] ^ b_r[W-1];

    fp_lzc #(.N(SW), .CW(LW)) u_lza (.a(sig_a), .cnt(lza));
    fp_lzc #(.N(SW), .CW(LW)) u_lzb (.a(sig_b), .cnt(lzb));

    // Subnormals carry exponent emin; the leading-zero count extends it below emin.
    assign ua = $signed(XW'(ea_f == '0 ? EXP_W'(1) : ea_f)) - $signed(XW'(BIAS)) - $signed(XW'(lza));
    assign ub = $signed(XW'(eb_f == '0 ? EXP_W'(1) : eb_f)) - $signed(XW'(BIAS)) - $signed(XW'(lzb));

    assign sp_inv  = ca == SNAN || cb == SNAN || (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF);
    assign sp_nan  = sp_inv || ca == QNAN || cb == QNAN;
    assign sp_inf  = ca == INF || cb == INF;
    assign special = sp_nan || sp_inf || ca == ZERO || cb == ZERO;
    assign sp_res  = sp_nan ? QNAN_W : sp_inf ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sgn, {(W-1){1'b0}}};

    // Round: normalise, denormalise when tiny, round to nearest even.
    logic top, tiny, st0, lost, g, rs, inc, ovf, inx;
    logic [PW-1:0] m;
    logic signed [XW-1:0] e_n, defc, dsh, bexp, fld;
    logic [VW-1:0] v, v_sh;
    logic [SW:0] sum;
    logic [MAN_W-1:0] frac;
    logic [W-1:0] rnd_res;

    always_comb begin
        top     = prod_r[PW-1];
        m       = top ? prod_r >> 1 : prod_r;
        e_n     = exp_r + $signed(XW'(top));
        tiny    = e_n < EMIN;
        defc    = EMIN - e_n;
        dsh     = !tiny ? '0 : (defc > DMAX ? DMAX : defc);
        v       = m[2*MAN_W -: VW];
        st0     = (top & prod_r[0]) | |(m & LO_MASK);
        v_sh    = v >> dsh;
        lost    = |(v & ~({VW{1'b1}} << dsh));
        g       = v_sh[1];
        rs      = v_sh[0] | st0 | lost;
        inc     = g & (rs | v_sh[2]);
        sum     = {1'b0, v_sh[VW-1:2]} + (SW+1)'(inc);
        bexp    = e_n + $signed(XW'(BIAS));
        // A tiny result becomes min-normal exactly when rounding sets the hidden bit.
        fld     = tiny ? $signed(XW'(sum[MAN_W])) : bexp + $signed(XW'(sum[SW]));
        frac    = sum[SW] ? '0 : sum[MAN_W-1:0];
        inx     = g | rs;
        ovf     = fld >= EMAX;
        rnd_res = ovf ? {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sign_r, fld[EXP_W-1:0], frac};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = i_valid ? UNPACK : IDLE;
            UNPACK:  state_nx = special ? DONE : MUL;
            MUL:     state_nx = cnt_r == '0 ? ROUND : MUL;
            ROUND:   state_nx = DONE;
            DONE:    state_nx = (o_valid && i_ready) ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb o_ready = state == IDLE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sign_r  <= 1'b0;
            exp_r   <= '0;
            ma_r    <= '0;
            mb_r    <= '0;
            prod_r  <= '0;
            cnt_r   <= '0;
            res_r   <= '0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
            inv_r   <= 1'b0;
            inx_r   <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_r <= i_a;
                        b_r <= i_b;
                    end
                end
                UNPACK: begin
                    sign_r <= sgn;
                    exp_r  <= ua + ub;
                    ma_r   <= sig_a << lza;
                    mb_r   <= sig_b << lzb;
                    prod_r <= '0;
                    cnt_r  <= CW'(MAN_W);
                    if (special) begin
                        res_r <= sp_res;
                        ovf_r <= 1'b0;
                        unf_r <= 1'b0;
                        inv_r <= sp_inv;
                        inx_r <= 1'b0;
                    end
                end
                MUL: begin
                    // Multiplier bits consumed MSB first, so the partial product shifts left.
                    prod_r <= (prod_r << 1) + PW'(mb_r[cnt_r] ? ma_r : '0);
                    cnt_r  <= cnt_r - 1'b1;
                end
                ROUND: begin
                    res_r <= rnd_res;
                    ovf_r <= ovf;
                    unf_r <= tiny & inx;
                    inv_r <= 1'b0;
                    inx_r <= inx | ovf;
                end
                DONE:    o_valid <= o_valid ? !i_ready : 1'b1;
                default: o_valid <= 1'b0;
            endcase
        end
    end

    assign o_res       = res_r;
    assign o_overflow  = ovf_r;
    assign o_underflow = unf_r;
    assign o_invalid   = inv_r;
    assign o_inexact   = inx_r;

endmodule
